// File: rtl/huc_timer_irq_if.sv
// huc_timer_irq_if
// CPU-side register bus for the HuC6280 timer / interrupt controller.
//   RDY     : CPU ready; register writes only commit while high
//   RE, WE  : read / write strobes
//   CET_n   : timer chip enable (from the MMU), active-low
//   CECG_n  : interrupt controller chip enable (from the MMU), active-low
//   addr    : VADDR[1:0]
//   d_in    : write data from the CPU
//   d_out   : read data returned by the block
//   d_oe    : high while the block drives d_out
// The master modport is the CPU/MMU side; the slave modport is the block.
interface huc_timer_irq_if;
    logic       RDY;
    logic       RE;
    logic       WE;
    logic       CET_n;
    logic       CECG_n;
    logic [1:0] addr;
    logic [7:0] d_in;
    logic [7:0] d_out;
    logic       d_oe;

    modport master (
        output RDY, RE, WE, CET_n, CECG_n, addr, d_in,
        input  d_out, d_oe
    );

    modport slave (
        input  RDY, RE, WE, CET_n, CECG_n, addr, d_in,
        output d_out, d_oe
    );
endinterface

// File: rtl/huc_timer_irq.sv
// huc_timer_irq
// HuC6280 on-chip timer and interrupt controller, sitting downstream of the
// MMU. The timer is a 7-bit reload down-counter clocked by a PRESCALE-cycle
// prescaler; each underflow latches a pending timer interrupt (TIQ). The
// interrupt controller masks TIQ and the two external level-sensitive IRQ
// pins and presents the result to the CPU's interrupt sequencer.
// Ports:
//   clk      : core clock
//   reset_n  : asynchronous reset, active-low
//   bus      : CPU register bus (slave side), see huc_timer_irq_if
//   IRQ1_n   : external IRQ1 (VDC), level, active-low
//   IRQ2_n   : external IRQ2, level, active-low
//   irq_req  : registered masked requests: [0] IRQ2, [1] IRQ1, [2] TIQ
module huc_timer_irq #(
    parameter int PRESCALE = 1024,
    parameter int CNT_W    = 7
) (
    input  logic            clk,
    input  logic            reset_n,
    huc_timer_irq_if.slave  bus,
    input  logic            IRQ1_n,
    input  logic            IRQ2_n,
    output logic [2:0]      irq_req
);

    localparam int PW = $clog2(PRESCALE);

    typedef enum logic {STOP, RUN} timer_state_t;

    timer_state_t      state, state_nx;
    logic [CNT_W-1:0]  count, count_nx;
    logic [CNT_W-1:0]  reload;
    logic [PW-1:0]     prescaler, pre_nx;
    logic [2:0]        mask;
    logic              tiq_pend;
    logic              tiq_set;

    logic wr_en, wr_t0, wr_t1, wr_i2, wr_i3;
    logic start_wr, stop_wr, tick;
    logic unused_d_in;

    assign unused_d_in = bus.d_in[7];

    // Register write decode; nothing commits while the CPU holds RDY low.
    assign wr_en = bus.WE & bus.RDY;
    assign wr_t0 = wr_en & ~bus.CET_n & ~bus.addr[0];
    assign wr_t1 = wr_en & ~bus.CET_n &  bus.addr[0];
    assign wr_i2 = wr_en & ~bus.CECG_n & (bus.addr == 2'd2);
    assign wr_i3 = wr_en & ~bus.CECG_n & (bus.addr == 2'd3);

    assign start_wr = wr_t1 &  bus.d_in[0];
    assign stop_wr  = wr_t1 & ~bus.d_in[0];
    assign tick     = (prescaler == PW'(PRESCALE - 1));

    // Timer state, counter and prescaler registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= STOP;
            count     <= '0;
            prescaler <= '0;
        end else begin
            state     <= state_nx;
            count     <= count_nx;
            prescaler <= pre_nx;
        end
    end

    // Timer next-state logic. A stop write outranks a coincident tick so a
    // stopped timer never shows a partial count step or a stray TIQ. A start
    // write while already running is ignored (no restart).
    always_comb begin
        state_nx = state;
        count_nx = count;
        pre_nx   = prescaler;
        tiq_set  = 1'b0;
        unique case (state)
            STOP: begin
                if (start_wr) begin
                    state_nx = RUN;
                    count_nx = reload;
                    pre_nx   = '0;
                end
            end
            RUN: begin
                if (stop_wr) begin
                    state_nx = STOP;
                end else begin
                    pre_nx = prescaler + PW'(1);
                    if (tick) begin
                        if (count != '0) begin
                            count_nx = count - CNT_W'(1);
                        end else begin
                            count_nx = reload;
                            tiq_set  = 1'b1;
                        end
                    end
                end
            end
            default: state_nx = STOP;
        endcase
    end

    // Control registers and the registered interrupt outputs. An underflow in
    // the same cycle as an acknowledge keeps the TIQ pending so it is not lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reload   <= '0;
            mask     <= 3'b000;
            tiq_pend <= 1'b0;
            irq_req  <= 3'b000;
        end else begin
            if (wr_t0) reload <= bus.d_in[CNT_W-1:0];
            if (wr_i2) mask   <= bus.d_in[2:0];
            tiq_pend <= tiq_set | (tiq_pend & ~wr_i3);
            irq_req  <= {tiq_pend & ~mask[2], ~IRQ1_n & ~mask[1], ~IRQ2_n & ~mask[0]};
        end
    end

    // Side-effect-free combinational read mux.
    always_comb begin
        bus.d_oe  = bus.RE & ~(bus.CET_n & bus.CECG_n);
        bus.d_out = 8'h00;
        if (bus.d_oe) begin
            if (!bus.CET_n) begin
                bus.d_out = 8'(count);
            end else begin
                unique case (bus.addr)
                    2'd2:    bus.d_out = {5'b0, mask};
                    2'd3:    bus.d_out = {5'b0, tiq_pend, ~IRQ1_n, ~IRQ2_n};
                    default: bus.d_out = 8'h00;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_huc_timer_irq.sv
// tb_huc_timer_irq
// Self-checking bench for huc_timer_irq. Directed scenarios followed by a
// randomized phase; every read and irq_req sample is compared against a
// behavioural model that tracks elapsed run time and timer segments.
module tb_huc_timer_irq;

    localparam int PRESCALE = 1024;

    logic       clk;
    logic       reset_n;
    logic       IRQ1_n;
    logic       IRQ2_n;
    logic [2:0] irq_req;

    int compared   = 0;
    int mismatched = 0;

    huc_timer_irq_if bus();

    huc_timer_irq #(.PRESCALE(PRESCALE), .CNT_W(7)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus),
        .IRQ1_n  (IRQ1_n),
        .IRQ2_n  (IRQ2_n),
        .irq_req (irq_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the count is derived from how long the timer has been
    // running, split into segments that each start at an underflow.
    int         mElapsed;
    int         mSegStart;
    int         mSegLoad;
    int         mReload;
    bit         mRun;
    bit         mTiq;
    logic [2:0] mMask;
    logic [2:0] mIrqReq;

    task automatic modelReset();
        mElapsed  = 0;
        mSegStart = 0;
        mSegLoad  = 0;
        mReload   = 0;
        mRun      = 0;
        mTiq      = 0;
        mMask     = 3'b000;
        mIrqReq   = 3'b000;
    endtask

    task automatic modelStep();
        logic       wr, tSel, iSel, under;
        logic [2:0] nextIrq;
        int         ticks;
        nextIrq = {mTiq & ~mMask[2], ~IRQ1_n & ~mMask[1], ~IRQ2_n & ~mMask[0]};
        wr      = bus.WE & bus.RDY;
        tSel    = wr & ~bus.CET_n;
        iSel    = wr & ~bus.CECG_n;
        under   = 1'b0;
        if (mRun) begin
            if (tSel && bus.addr[0] && !bus.d_in[0]) begin
                mRun = 0;
            end else begin
                mElapsed = mElapsed + 1;
                if (mElapsed % PRESCALE == 0) begin
                    ticks = mElapsed / PRESCALE;
                    if (ticks - mSegStart > mSegLoad) begin
                        under     = 1'b1;
                        mSegStart = ticks;
                        mSegLoad  = mReload;
                    end
                end
            end
        end else if (tSel && bus.addr[0] && bus.d_in[0]) begin
            mRun      = 1;
            mElapsed  = 0;
            mSegStart = 0;
            mSegLoad  = mReload;
        end
        if (tSel && !bus.addr[0]) mReload = int'(bus.d_in[6:0]);
        if (iSel && bus.addr == 2'd2) mMask = bus.d_in[2:0];
        if (under) mTiq = 1;
        else if (iSel && bus.addr == 2'd3) mTiq = 0;
        mIrqReq = nextIrq;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) modelReset();
        else          modelStep();
    end

    function automatic logic [7:0] modelRead(input logic cet, input logic cecg, input logic [1:0] a);
        int c;
        c = mSegLoad - (mElapsed / PRESCALE - mSegStart);
        if (!cet)  return 8'(c);
        if (!cecg) begin
            if (a == 2'd2) return {5'b0, mMask};
            if (a == 2'd3) return {5'b0, mTiq, ~IRQ1_n, ~IRQ2_n};
        end
        return 8'h00;
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drives one write for the next rising edge; returns on the following negedge.
    task automatic applyStimulus(input logic cet, input logic cecg, input logic [1:0] a,
                                 input logic [7:0] d, input logic rdy);
        bus.WE     = 1'b1;
        bus.RDY    = rdy;
        bus.CET_n  = cet;
        bus.CECG_n = cecg;
        bus.addr   = a;
        bus.d_in   = d;
        @(negedge clk);
        bus.WE     = 1'b0;
        bus.RDY    = 1'b1;
        bus.CET_n  = 1'b1;
        bus.CECG_n = 1'b1;
    endtask

    task automatic readReg(input logic cet, input logic cecg, input logic [1:0] a,
                           output logic [7:0] data, output logic oe);
        bus.RE     = 1'b1;
        bus.CET_n  = cet;
        bus.CECG_n = cecg;
        bus.addr   = a;
        #1;
        data       = bus.d_out;
        oe         = bus.d_oe;
        bus.RE     = 1'b0;
        bus.CET_n  = 1'b1;
        bus.CECG_n = 1'b1;
    endtask

    // Reads a register, checks it against the model and, if given, a constant.
    task automatic checkReg(input string tag, input logic cet, input logic cecg,
                            input logic [1:0] a, input bit useConst, input logic [7:0] constExp);
        logic [7:0] data;
        logic       oe;
        logic [7:0] mexp;
        mexp = modelRead(cet, cecg, a);
        readReg(cet, cecg, a, data, oe);
        checkOutput({tag, "_model"}, data, mexp);
        checkOutput({tag, "_oe"}, {7'b0, oe}, {7'b0, ~(cet & cecg)});
        if (useConst) checkOutput({tag, "_const"}, data, constExp);
    endtask

    task automatic checkIrq(input string tag, input bit useConst, input logic [2:0] constExp);
        checkOutput({tag, "_irq_model"}, {5'b0, irq_req}, {5'b0, mIrqReq});
        if (useConst) checkOutput({tag, "_irq_const"}, {5'b0, irq_req}, {5'b0, constExp});
    endtask

    initial begin
        logic [7:0] data;
        logic       oe;
        int         op, sel;

        reset_n    = 1'b0;
        IRQ1_n     = 1'b1;
        IRQ2_n     = 1'b1;
        bus.RDY    = 1'b1;
        bus.RE     = 1'b0;
        bus.WE     = 1'b0;
        bus.CET_n  = 1'b1;
        bus.CECG_n = 1'b1;
        bus.addr   = 2'd0;
        bus.d_in   = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        checkIrq("rst", 1, 3'b000);
        checkOutput("rst_dout", bus.d_out, 8'h00);
        checkOutput("rst_doe", {7'b0, bus.d_oe}, 8'h00);
        checkReg("rst_t0", 0, 1, 2'd0, 1, 8'h00);
        checkReg("rst_i2", 1, 0, 2'd2, 1, 8'h00);
        reset_n = 1'b1;
        step(1);

        // RDY low blocks the reload write; start loads the committed reload
        applyStimulus(0, 1, 2'd0, 8'd9, 1);
        applyStimulus(0, 1, 2'd0, 8'd5, 0);
        applyStimulus(0, 1, 2'd1, 8'h01, 1);
        checkReg("rdy_gate", 0, 1, 2'd0, 1, 8'd9);
        applyStimulus(0, 1, 2'd1, 8'h00, 1);

        // IRQ1 level path and masking
        IRQ1_n = 1'b0;
        step(1);
        checkIrq("irq1_on", 1, 3'b010);
        checkReg("irq1_i3", 1, 0, 2'd3, 1, 8'h02);
        applyStimulus(1, 0, 2'd2, 8'h02, 1);
        step(1);
        checkIrq("irq1_mask", 1, 3'b000);
        IRQ1_n = 1'b1;
        applyStimulus(1, 0, 2'd2, 8'h00, 1);
        step(1);

        // Period: reload 3 -> TIQ 4*1024 cycles after start, registered one later
        applyStimulus(0, 1, 2'd0, 8'd3, 1);
        applyStimulus(0, 1, 2'd1, 8'h01, 1);
        step(4096);
        checkIrq("period_pre", 1, 3'b000);
        step(1);
        checkIrq("period_1st", 1, 3'b100);
        checkReg("period_i3", 1, 0, 2'd3, 1, 8'h04);
        applyStimulus(1, 0, 2'd3, 8'h5a, 1);
        step(4094);
        checkIrq("period_ack", 1, 3'b000);
        step(1);
        checkIrq("period_2nd", 1, 3'b100);

        // Masking keeps TIQ pending
        applyStimulus(1, 0, 2'd2, 8'h04, 1);
        step(1);
        checkIrq("mask_on", 1, 3'b000);
        checkReg("mask_i3", 1, 0, 2'd3, 1, 8'h04);
        checkReg("mask_i2", 1, 0, 2'd2, 1, 8'h04);
        applyStimulus(1, 0, 2'd2, 8'h00, 1);
        step(1);
        checkIrq("mask_off", 1, 3'b100);
        applyStimulus(0, 1, 2'd1, 8'h00, 1);
        applyStimulus(1, 0, 2'd3, 8'h00, 1);

        // Race: acknowledge in the exact underflow cycle leaves TIQ pending
        applyStimulus(0, 1, 2'd0, 8'd0, 1);
        applyStimulus(0, 1, 2'd1, 8'h01, 1);
        step(1499);
        applyStimulus(1, 0, 2'd3, 8'h00, 1);
        checkReg("race_clr", 1, 0, 2'd3, 1, 8'h00);
        step(547);
        applyStimulus(1, 0, 2'd3, 8'h00, 1);
        checkReg("race_set", 1, 0, 2'd3, 1, 8'h04);
        applyStimulus(0, 1, 2'd1, 8'h00, 1);
        applyStimulus(1, 0, 2'd3, 8'h00, 1);

        // Stop/hold: stop coincident with the tick to 6 holds 7
        applyStimulus(0, 1, 2'd0, 8'd10, 1);
        applyStimulus(0, 1, 2'd1, 8'h01, 1);
        step(4095);
        applyStimulus(0, 1, 2'd1, 8'h00, 1);
        checkReg("stop_hold", 0, 1, 2'd1, 1, 8'd7);
        step(3000);
        checkReg("stop_later", 0, 1, 2'd0, 1, 8'd7);
        checkReg("stop_notiq", 1, 0, 2'd3, 1, 8'h00);
        applyStimulus(0, 1, 2'd1, 8'h01, 1);
        checkReg("restart", 0, 1, 2'd0, 1, 8'd10);
        applyStimulus(0, 1, 2'd1, 8'h01, 1);
        step(1200);
        checkReg("no_restart", 0, 1, 2'd0, 1, 8'd9);

        // Reset pulse mid-run
        reset_n = 1'b0;
        #1;
        checkOutput("rstmid_irq", {5'b0, irq_req}, 8'h00);
        readReg(0, 1, 2'd0, data, oe);
        checkOutput("rstmid_t0", data, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        step(5000);
        checkIrq("rstmid_quiet", 1, 3'b000);
        checkReg("rstmid_i3", 1, 0, 2'd3, 1, 8'h00);
        checkReg("rstmid_cnt", 0, 1, 2'd0, 1, 8'h00);

        // Randomized phase against the model
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 6));
            case (op)
                0: applyStimulus(0, 1, 2'(2 * $urandom_range(0, 1)),
                                 {1'($urandom_range(0, 1)), 7'($urandom_range(0, 3))}, 1);
                1: applyStimulus(0, 1, 2'd1, 8'($urandom), 1);
                2: applyStimulus(1, 0, 2'd2, 8'($urandom), 1);
                3: applyStimulus(1, 0, 2'd3, 8'($urandom), 1);
                4: begin
                    IRQ1_n = 1'($urandom);
                    IRQ2_n = 1'($urandom);
                end
                5: applyStimulus(1'($urandom), 1'($urandom), 2'($urandom), 8'($urandom), 0);
                default: ;
            endcase
            step(int'($urandom_range(0, 700)));
            sel = int'($urandom_range(0, 2));
            if (sel == 0)      checkReg("rnd_t", 0, 1, 2'($urandom), 0, 8'h00);
            else if (sel == 1) checkReg("rnd_i", 1, 0, 2'($urandom), 0, 8'h00);
            else               checkReg("rnd_none", 1, 1, 2'($urandom), 1, 8'h00);
            checkIrq("rnd", 0, 3'b000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
